// File: rtl/dram_pkg.sv
// Shared widths, tdata field offsets and the request record for the DRAM read scheduler.
package dram_pkg;

  localparam int N_CHANNELS_DEF   = 8;
  localparam int ADDR_WIDTH_DEF   = 24;
  localparam int PERIOD_WIDTH_DEF = 14;

  // Channel index width, never below one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // tdata is {channel, period, addr} with addr in the low bits.
  function automatic int addr_lsb();
    return 0;
  endfunction

  function automatic int period_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int ch_lsb(input int addr_w, input int period_w);
    return addr_w + period_w;
  endfunction

  localparam int CH_W = ch_width(N_CHANNELS_DEF);

  typedef struct packed {
    logic [CH_W-1:0]             ch;
    logic [PERIOD_WIDTH_DEF-1:0] period;
    logic [ADDR_WIDTH_DEF-1:0]   addr;
  } req_t;

endpackage

// File: rtl/dram_read_scheduler_if.sv
// Channel request/grant bus and AXI-Stream request output of the DRAM read scheduler.
interface dram_read_scheduler_if #(
  parameter int N_CHANNELS   = 8,
  parameter int ADDR_WIDTH   = 24,
  parameter int PERIOD_WIDTH = 14
);
  import dram_pkg::*;

  localparam int CHW     = ch_width(N_CHANNELS);
  localparam int TDATA_W = CHW + PERIOD_WIDTH + ADDR_WIDTH;

  logic [N_CHANNELS-1:0]                 ch_valid;
  logic [N_CHANNELS-1:0][ADDR_WIDTH-1:0] ch_addr;
  logic [N_CHANNELS-1:0]                 ch_ready;
  logic                                  m_axis_tvalid;
  logic                                  m_axis_tready;
  logic [TDATA_W-1:0]                    m_axis_tdata;
  logic                                  m_axis_tlast;

  modport master (
    input  ch_valid, ch_addr, m_axis_tready,
    output ch_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output ch_valid, ch_addr, m_axis_tready,
    input  ch_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

endinterface

// File: rtl/dram_read_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1 and flags the last requester before wrap.
module rr_arbiter #(
  parameter int N_CHANNELS = 8,
  parameter int CH_W       = 3
) (
  input  logic [N_CHANNELS-1:0] req,
  input  logic [CH_W-1:0]       last_grant,
  output logic [N_CHANNELS-1:0] grant,
  output logic [CH_W-1:0]       index,
  output logic                  any,
  output logic                  wrap
);

  int cand;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    grant = '0;
    index = '0;
    any   = 1'b0;
    wrap  = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N_CHANNELS; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= N_CHANNELS) cand = cand - N_CHANNELS;
      if (!any && req[cand]) begin
        any         = 1'b1;
        index       = CH_W'(cand);
        grant[cand] = 1'b1;
      end
    end
    // Wrap when no higher-numbered channel is still requesting.
    wrap = any;
    for (int j = 0; j < N_CHANNELS; j++) begin
      if (req[j] && (j > int'(index))) wrap = 1'b0;
    end
  end

endmodule

// File: rtl/dram_read_scheduler.sv
// Round-robin DRAM read scheduler with chunk sample counter and period latch.
// Optional macro DRAM_SCHED_STALL_CNT_EN adds the saturating stall_count output.
module dram_read_scheduler
  import dram_pkg::*;
#(
  parameter int N_CHANNELS     = 8,
  parameter int ADDR_WIDTH     = 24,
  parameter int PERIOD_WIDTH   = 14,
  parameter int CHUNK_SAMPLES  = 8,
  parameter int DEFAULT_PERIOD = 2272
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic [PERIOD_WIDTH-1:0]                       sample_period,
  dram_read_scheduler_if.master                         bus,
  output logic [PERIOD_WIDTH+$clog2(CHUNK_SAMPLES)-1:0] sample_counter,
  output logic [PERIOD_WIDTH-1:0]                       period_hold
`ifdef DRAM_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]                                   stall_count
`endif
);

  localparam int CHW        = ch_width(N_CHANNELS);
  localparam int LOG2_CHUNK = $clog2(CHUNK_SAMPLES);
  localparam int CNT_W      = PERIOD_WIDTH + LOG2_CHUNK;
  localparam int TDATA_W    = CHW + PERIOD_WIDTH + ADDR_WIDTH;
  localparam int CH_LSB     = ch_lsb(ADDR_WIDTH, PERIOD_WIDTH);
  localparam int PERIOD_LSB = period_lsb(ADDR_WIDTH);
  localparam int ADDR_LSB   = addr_lsb();

  logic [CHW-1:0]        last_grant;
  logic [CHW-1:0]        grant_idx;
  logic [N_CHANNELS-1:0] grant_onehot;
  logic                  grant_any;
  logic                  grant_wrap;
  logic                  slot_free;
  logic                  do_grant;
  logic [TDATA_W-1:0]    next_tdata;
  logic [CNT_W-1:0]      chunk_last;

  rr_arbiter #(.N_CHANNELS(N_CHANNELS), .CH_W(CHW)) u_arb (
    .req        (bus.ch_valid),
    .last_grant (last_grant),
    .grant      (grant_onehot),
    .index      (grant_idx),
    .any        (grant_any),
    .wrap       (grant_wrap)
  );

  assign slot_free    = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign do_grant     = slot_free && en && grant_any && !rst;
  assign bus.ch_ready = do_grant ? grant_onehot : '0;

  always_comb begin
    next_tdata = '0;
    next_tdata[CH_LSB +: CHW]              = grant_idx;
    next_tdata[PERIOD_LSB +: PERIOD_WIDTH] = period_hold;
    next_tdata[ADDR_LSB +: ADDR_WIDTH]     = bus.ch_addr[grant_idx];
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tlast  <= 1'b0;
      last_grant        <= CHW'(N_CHANNELS - 1);
    end else if (do_grant) begin
      bus.m_axis_tvalid <= 1'b1;
      bus.m_axis_tdata  <= next_tdata;
      bus.m_axis_tlast  <= grant_wrap;
      last_grant        <= grant_idx;
    end else if (bus.m_axis_tready) begin
      bus.m_axis_tvalid <= 1'b0;
    end
  end

  // Terminal count computed at full counter width so period*CHUNK cannot overflow.
  assign chunk_last = (CNT_W'(period_hold) << LOG2_CHUNK) - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_counter <= '0;
      period_hold    <= PERIOD_WIDTH'(DEFAULT_PERIOD);
    end else if (sample_counter == chunk_last) begin
      sample_counter <= '0;
      if (sample_period != '0) period_hold <= sample_period;
    end else begin
      sample_counter <= sample_counter + CNT_W'(1);
    end
  end

`ifdef DRAM_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (bus.m_axis_tvalid && !bus.m_axis_tready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_read_scheduler.sv
// Directed self-checking bench for dram_read_scheduler (default parameters).
module tb_dram_read_scheduler;
  import dram_pkg::*;

  localparam int N  = 8;
  localparam int AW = 24;
  localparam int PW = 14;
  localparam int CS = 8;
  localparam int DP = 2272;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [PW-1:0] sample_period;
  logic [16:0]   sample_counter;
  logic [PW-1:0] period_hold;
`ifdef DRAM_SCHED_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  dram_read_scheduler_if #(.N_CHANNELS(N), .ADDR_WIDTH(AW), .PERIOD_WIDTH(PW)) bus ();

  dram_read_scheduler #(
    .N_CHANNELS(N), .ADDR_WIDTH(AW), .PERIOD_WIDTH(PW),
    .CHUNK_SAMPLES(CS), .DEFAULT_PERIOD(DP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .sample_period  (sample_period),
    .bus            (bus.master),
    .sample_counter (sample_counter),
    .period_hold    (period_hold)
`ifdef DRAM_SCHED_STALL_CNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int k);
    return AW'(32'hA00000 + k * 32'h10101);
  endfunction

  function automatic req_t cur();
    return req_t'(bus.m_axis_tdata);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; bus.ch_valid = '0; bus.m_axis_tready = 1'b0; sample_period = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_t r;
    @(negedge clk);
    rst = 1'b1; en = 1'b1; bus.ch_valid = 8'hFF; bus.m_axis_tready = 1'b1; sample_period = '0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (bus.m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_axis_tvalid); end
    tests_run++; if (bus.m_axis_tlast !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b expected 0", bus.m_axis_tlast); end
    tests_run++; if (bus.m_axis_tdata !== '0) begin tests_failed++; $display("FAIL reset_tdata: got %h expected 0", bus.m_axis_tdata); end
    tests_run++; if (bus.ch_ready !== 8'h00) begin tests_failed++; $display("FAIL reset_ch_ready: got %h expected 00", bus.ch_ready); end
    tests_run++; if (sample_counter !== 17'd0) begin tests_failed++; $display("FAIL reset_counter: got %0d expected 0", sample_counter); end
    tests_run++; if (period_hold !== PW'(DP)) begin tests_failed++; $display("FAIL reset_period_hold: got %0d expected %0d", period_hold, DP); end
    rst = 1'b0;
    #1;
    tests_run++; if (bus.ch_ready !== 8'h01) begin tests_failed++; $display("FAIL reset_first_grant: got %h expected 01", bus.ch_ready); end
    @(negedge clk);
    r = cur();
    tests_run++; if (r.ch !== CH_W'(0)) begin tests_failed++; $display("FAIL reset_first_ch: got %0d expected 0", r.ch); end
  endtask

  task automatic test_all_valid();
    req_t r;
    do_reset();
    en = 1'b1; bus.m_axis_tready = 1'b1; bus.ch_valid = 8'hFF;
    #1;
    for (int i = 0; i < N; i++) begin
      tests_run++; if (bus.ch_ready !== 8'(1 << i)) begin tests_failed++; $display("FAIL all_ready[%0d]: got %h expected %h", i, bus.ch_ready, 8'(1 << i)); end
      @(negedge clk);
      r = cur();
      tests_run++; if (bus.m_axis_tvalid !== 1'b1) begin tests_failed++; $display("FAIL all_tvalid[%0d]: got %b expected 1", i, bus.m_axis_tvalid); end
      tests_run++; if (r.ch !== CH_W'(i)) begin tests_failed++; $display("FAIL all_ch[%0d]: got %0d expected %0d", i, r.ch, i); end
      tests_run++; if (r.addr !== addr_of(i)) begin tests_failed++; $display("FAIL all_addr[%0d]: got %h expected %h", i, r.addr, addr_of(i)); end
      tests_run++; if (r.period !== PW'(DP)) begin tests_failed++; $display("FAIL all_period[%0d]: got %0d expected %0d", i, r.period, DP); end
      tests_run++; if (bus.m_axis_tlast !== (i == 7)) begin tests_failed++; $display("FAIL all_tlast[%0d]: got %b expected %b", i, bus.m_axis_tlast, (i == 7)); end
    end
  endtask

  task automatic test_alternate();
    req_t r;
    int exp_ch [4] = '{2, 5, 2, 5};
    do_reset();
    en = 1'b1; bus.m_axis_tready = 1'b1; bus.ch_valid = 8'b0010_0100;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (bus.ch_ready !== 8'(1 << exp_ch[i])) begin tests_failed++; $display("FAIL alt_ready[%0d]: got %h expected %h", i, bus.ch_ready, 8'(1 << exp_ch[i])); end
      @(negedge clk);
      r = cur();
      tests_run++; if (r.ch !== CH_W'(exp_ch[i])) begin tests_failed++; $display("FAIL alt_ch[%0d]: got %0d expected %0d", i, r.ch, exp_ch[i]); end
      tests_run++; if (bus.m_axis_tlast !== (exp_ch[i] == 5)) begin tests_failed++; $display("FAIL alt_tlast[%0d]: got %b expected %b", i, bus.m_axis_tlast, (exp_ch[i] == 5)); end
    end
  endtask

  task automatic test_stall();
    req_t e;
    e.ch = CH_W'(3); e.period = PW'(DP); e.addr = addr_of(3);
    do_reset();
    en = 1'b1; bus.m_axis_tready = 1'b0; bus.ch_valid = 8'h08;
    #1;
    tests_run++; if (bus.ch_ready !== 8'h08) begin tests_failed++; $display("FAIL stall_grant: got %h expected 08", bus.ch_ready); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      tests_run++; if (bus.m_axis_tvalid !== 1'b1) begin tests_failed++; $display("FAIL stall_tvalid[%0d]: got %b expected 1", s, bus.m_axis_tvalid); end
      tests_run++; if (bus.m_axis_tdata !== e) begin tests_failed++; $display("FAIL stall_tdata[%0d]: got %h expected %h", s, bus.m_axis_tdata, e); end
      tests_run++; if (bus.ch_ready !== 8'h00) begin tests_failed++; $display("FAIL stall_ready[%0d]: got %h expected 00", s, bus.ch_ready); end
`ifdef DRAM_SCHED_STALL_CNT_EN
      tests_run++; if (stall_count !== 16'(s)) begin tests_failed++; $display("FAIL stall_count[%0d]: got %0d expected %0d", s, stall_count, s); end
`endif
      if (s == 2) en = 1'b0;
    end
    @(negedge clk);
`ifdef DRAM_SCHED_STALL_CNT_EN
    tests_run++; if (stall_count !== 16'd5) begin tests_failed++; $display("FAIL stall_count_total: got %0d expected 5", stall_count); end
`endif
    bus.m_axis_tready = 1'b1;
    #1;
    tests_run++; if (bus.ch_ready !== 8'h00) begin tests_failed++; $display("FAIL en_low_ready: got %h expected 00", bus.ch_ready); end
    @(negedge clk);
    tests_run++; if (bus.m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL en_low_drain: got %b expected 0", bus.m_axis_tvalid); end
    tests_run++; if (bus.ch_ready !== 8'h00) begin tests_failed++; $display("FAIL en_low_no_grant: got %h expected 00", bus.ch_ready); end
`ifdef DRAM_SCHED_STALL_CNT_EN
    tests_run++; if (stall_count !== 16'd5) begin tests_failed++; $display("FAIL stall_count_after: got %0d expected 5", stall_count); end
`endif
  endtask

  task automatic test_reset_mid();
    req_t r;
    do_reset();
    en = 1'b1; bus.m_axis_tready = 1'b0; bus.ch_valid = 8'h10;
    @(negedge clk);
    r = cur();
    tests_run++; if (r.ch !== CH_W'(4)) begin tests_failed++; $display("FAIL mid_held_ch: got %0d expected 4", r.ch); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_tvalid: got %b expected 0", bus.m_axis_tvalid); end
    bus.ch_valid = 8'hFF; bus.m_axis_tready = 1'b1;
    #1;
    tests_run++; if (bus.ch_ready !== 8'h00) begin tests_failed++; $display("FAIL mid_ready_in_rst: got %h expected 00", bus.ch_ready); end
    rst = 1'b0;
    #1;
    tests_run++; if (bus.ch_ready !== 8'h01) begin tests_failed++; $display("FAIL mid_regrant: got %h expected 01", bus.ch_ready); end
    @(negedge clk);
    r = cur();
    tests_run++; if (r.ch !== CH_W'(0)) begin tests_failed++; $display("FAIL mid_regrant_ch: got %0d expected 0", r.ch); end
  endtask

  task automatic test_en_gate();
    req_t r;
    do_reset();
    en = 1'b0; bus.ch_valid = 8'hFF; bus.m_axis_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (bus.ch_ready !== 8'h00) begin tests_failed++; $display("FAIL en_off_ready[%0d]: got %h expected 00", c, bus.ch_ready); end
      @(negedge clk);
      tests_run++; if (bus.m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL en_off_tvalid[%0d]: got %b expected 0", c, bus.m_axis_tvalid); end
    end
    en = 1'b1;
    #1;
    tests_run++; if (bus.ch_ready !== 8'h01) begin tests_failed++; $display("FAIL en_on_ready: got %h expected 01", bus.ch_ready); end
    @(negedge clk);
    r = cur();
    tests_run++; if (bus.m_axis_tvalid !== 1'b1 || r.ch !== CH_W'(0)) begin tests_failed++; $display("FAIL en_on_ch: got tvalid=%b ch=%0d expected tvalid=1 ch=0", bus.m_axis_tvalid, r.ch); end
  endtask

  task automatic test_period();
    int n;
    do_reset();
    n = 0;
    repeat (100) begin @(negedge clk); n++; end
    tests_run++; if (sample_counter !== 17'd100) begin tests_failed++; $display("FAIL period_count100: got %0d expected 100", sample_counter); end
    sample_period = PW'(1000);
    while (sample_counter !== 17'd18175 && n < 20000) begin @(negedge clk); n++; end
    tests_run++; if (n !== 18175) begin tests_failed++; $display("FAIL period_wrap_cycle: got %0d expected 18175", n); end
    tests_run++; if (period_hold !== PW'(DP)) begin tests_failed++; $display("FAIL period_hold_before: got %0d expected %0d", period_hold, DP); end
    @(negedge clk);
    tests_run++; if (sample_counter !== 17'd0) begin tests_failed++; $display("FAIL period_wrap_zero: got %0d expected 0", sample_counter); end
    tests_run++; if (period_hold !== PW'(1000)) begin tests_failed++; $display("FAIL period_hold_new: got %0d expected 1000", period_hold); end
    sample_period = '0;
    n = 0;
    while (sample_counter !== 17'd7999 && n < 9000) begin @(negedge clk); n++; end
    tests_run++; if (n !== 7999) begin tests_failed++; $display("FAIL period_wrap2_cycle: got %0d expected 7999", n); end
    @(negedge clk);
    tests_run++; if (sample_counter !== 17'd0) begin tests_failed++; $display("FAIL period_wrap2_zero: got %0d expected 0", sample_counter); end
    tests_run++; if (period_hold !== PW'(1000)) begin tests_failed++; $display("FAIL period_zero_ignored: got %0d expected 1000", period_hold); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sample_period = '0;
    bus.ch_valid = '0; bus.m_axis_tready = 1'b0;
    for (int k = 0; k < N; k++) bus.ch_addr[k] = addr_of(k);
    test_reset();
    test_all_valid();
    test_alternate();
    test_stall();
    test_reset_mid();
    test_en_gate();
    test_period();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dram_read_scheduler.md
DRAM_READ_SCHEDULER -- requirements
Module: dram_read_scheduler

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 8, number of requesting channels (2..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 24, DRAM word address width.
REQ-003 SHALL have parameter PERIOD_WIDTH, default 14, sample period width in clk cycles.
REQ-004 SHALL have parameter CHUNK_SAMPLES, default 8, samples per chunk (power of two).
REQ-005 SHALL have parameter DEFAULT_PERIOD, default 2272, period held after reset.
REQ-006 SHALL have ports: clk in 1, system clock; rst in 1, reset.
REQ-007 SHALL have ports: en in 1, scheduling enable (setup complete); sample_period in PERIOD_WIDTH, requested period.
REQ-008 SHALL have ports: ch_valid in N_CHANNELS, per-channel request; ch_addr in N_CHANNELS x ADDR_WIDTH, per-channel address; ch_ready out N_CHANNELS, per-channel grant.
REQ-009 SHALL have ports: m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tdata out CH_W+PERIOD_WIDTH+ADDR_WIDTH, {channel, period, addr}; m_axis_tlast out 1.
REQ-010 SHALL have ports: sample_counter out PERIOD_WIDTH+log2(CHUNK_SAMPLES), chunk cycle count; period_hold out PERIOD_WIDTH, latched period.
REQ-011 SHALL use one clock, clk; rst synchronous, active-high.

Function
REQ-012 SHALL hold a single output register; slot is free when !m_axis_tvalid or (m_axis_tvalid & m_axis_tready).
REQ-013 SHALL, when slot free and en=1, grant the first channel k with ch_valid[k]=1, searching round-robin from last_grant+1 mod N_CHANNELS.
REQ-014 SHALL assert ch_ready[k] combinationally in the grant cycle only; at most one ch_ready bit high; all low if slot not free or en=0.
REQ-015 SHALL load {k, period_hold, ch_addr[k]} into the output register at the grant-cycle edge: 1-cycle latency to m_axis_tvalid.
REQ-016 SHALL keep tdata/tlast stable while m_axis_tvalid & !m_axis_tready.
REQ-017 SHALL sustain one request per cycle when m_axis_tready=1 and requests are pending (no bubble).
REQ-018 SHALL assert m_axis_tlast with a request whose channel index is N_CHANNELS-1 or is the last valid channel before round-robin wraps.
REQ-019 SHALL update last_grant to k on every grant; a channel with ch_valid low is skipped without consuming a cycle.
REQ-020 SHALL count sample_counter 0..period_hold*CHUNK_SAMPLES-1, wrap to 0, and at the wrap cycle latch sample_period into period_hold.
REQ-021 SHALL ignore sample_period=0 at latch time (period_hold unchanged).
REQ-022 SHALL, on en falling while a request is held, still present it until accepted; no new grants.
REQ-023 SHALL compute chunk terminal count at PERIOD_WIDTH+log2(CHUNK_SAMPLES) bits without overflow.

Reset
REQ-024 SHALL, on rst, drive m_axis_tvalid=0, tlast=0, tdata=0, ch_ready=0, sample_counter=0, period_hold=DEFAULT_PERIOD, last_grant=N_CHANNELS-1.
REQ-025 SHALL discard any held request on rst mid-transfer; first grant after reset favors channel 0.

Configuration
REQ-026 SHALL compile, with DRAM_SCHED_STALL_CNT_EN defined, output stall_count[15:0]: saturating count of cycles with m_axis_tvalid & !m_axis_tready, cleared by rst.
REQ-027 SHALL, without DRAM_SCHED_STALL_CNT_EN, omit the port and counter entirely.

Structure
REQ-028 SHALL place CH_W=max(1,$clog2(N_CHANNELS)), tdata field offsets, and the request struct typedef in shared package dram_pkg.
REQ-029 SHALL implement arbitration in sub-module rr_arbiter (request vector, last_grant -> one-hot grant, index, wrap flag).

Verification
REQ-030 SHALL cover: ch_valid=8'hFF, tready=1 -> grants ch0..ch7 on consecutive cycles, tlast only with ch7.
REQ-031 SHALL cover: ch_valid=8'b0010_0100 -> ch2, ch5, ch2 alternate; tlast on ch5.
REQ-032 SHALL cover: tready=0 for 5 cycles with ch3 pending -> tdata held, no ch_ready, stall_count=5 (macro on).
REQ-033 SHALL cover: sample_period changed to 1000 mid-chunk -> period_hold stays 2272 until sample_counter wraps at 18175, then 1000; sample_period=0 -> unchanged.
REQ-034 SHALL cover: rst asserted while tvalid=1 & tready=0 -> tvalid=0 next cycle, next grant is ch0.
REQ-035 SHALL cover: en=0 with all ch_valid high -> no grants; en=1 -> ch0 granted same cycle.
